// File: rtl/riscv_imem_loader_pkg.sv
// riscv_imem_loader_pkg: shared configuration for the imem boot loader.
// XLEN, IMEM_ADDR_BIT, byte-index width and FSM encoding.
// RISCV_IMEM_LOADER_CKSUM_EN adds the CKSUM state.
package riscv_imem_loader_pkg;

  localparam int XLEN          = 32;
  localparam int IMEM_ADDR_BIT = 6;
  localparam int IDX_W         = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
`ifdef RISCV_IMEM_LOADER_CKSUM_EN
    S_CKSUM,
`endif
    S_DONE
  } state_t;

  function automatic logic idx_last(
    input logic [IDX_W-1:0] idx
  );
    return &idx;
  endfunction

endpackage

// File: rtl/riscv_imem_loader_packer.sv
// riscv_imem_loader_packer: little-endian byte-to-word assembler.
// Ports: clk/rst, clr restarts the index, take shifts data in;
// last flags the 4th byte, word is the assembled word on that byte.
module riscv_imem_loader_packer
  import riscv_imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        take,
  input  logic [7:0]  data,
  output logic        last,
  output logic [31:0] word
);

  logic [IDX_W-1:0] idx;
  logic [23:0]      acc;

  // Bytes enter at the top and shift down, so after three
  // bytes acc holds {b2,b1,b0} and the 4th byte completes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      acc <= '0;
    end else if (clr) begin
      idx <= '0;
      acc <= '0;
    end else if (take) begin
      idx <= idx + 1'b1;
      acc <= {data, acc[23:8]};
    end
  end

  assign last = idx_last(idx);
  assign word = {data, acc};

endmodule

// File: rtl/riscv_imem_loader.sv
// riscv_imem_loader: byte-stream boot loader for the instruction memory.
// Ports: i_clk, i_rst (async high), i_start, i_byte/i_byte_valid/
// o_byte_ready stream, o_imem_we/waddr/wdata write port,
// o_core_rst, o_done, o_err (sticky until next i_start).
// Define RISCV_IMEM_LOADER_CKSUM_EN for the checksum trailer.
module riscv_imem_loader
  import riscv_imem_loader_pkg::*;
#(
  parameter int P_XLEN = XLEN,
  parameter int P_AW   = IMEM_ADDR_BIT - 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [7:0]        i_byte,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  output logic              o_imem_we,
  output logic [P_AW-1:0]   o_imem_waddr,
  output logic [P_XLEN-1:0] o_imem_wdata,
  output logic              o_core_rst,
  output logic              o_done,
  output logic              o_err
);

  localparam logic [P_AW-1:0] LAST_ADDR = '1;

  state_t          state;
  logic [31:0]     remain;
  logic [P_AW-1:0] addr;
  logic            full;
  logic            take;
  logic            start_ok;
  logic            last;
  logic [31:0]     word;
  logic            word_end;

`ifdef RISCV_IMEM_LOADER_CKSUM_EN
  logic [31:0]     sum;
`endif

  assign take     = i_byte_valid & o_byte_ready;
  assign word_end = take & last;
  assign start_ok = i_start &
                    ((state == S_IDLE) | (state == S_DONE));

  riscv_imem_loader_packer u_packer (
    .clk  (i_clk),
    .rst  (i_rst),
    .clr  (start_ok),
    .take (take),
    .data (i_byte),
    .last (last),
    .word (word)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_IDLE;
      remain       <= '0;
      addr         <= '0;
      full         <= 1'b0;
      o_byte_ready <= 1'b0;
      o_imem_we    <= 1'b0;
      o_imem_waddr <= '0;
      o_imem_wdata <= '0;
      o_core_rst   <= 1'b1;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
`ifdef RISCV_IMEM_LOADER_CKSUM_EN
      sum          <= '0;
`endif
    end else begin
      o_imem_we <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            state        <= S_LEN;
            remain       <= '0;
            addr         <= '0;
            full         <= 1'b0;
            o_byte_ready <= 1'b1;
            o_core_rst   <= 1'b1;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
`ifdef RISCV_IMEM_LOADER_CKSUM_EN
            sum          <= '0;
`endif
          end
        end
        S_LEN: begin
          if (word_end) begin
            remain <= word;
            if (word == '0) begin
`ifdef RISCV_IMEM_LOADER_CKSUM_EN
              state        <= S_CKSUM;
`else
              state        <= S_DONE;
              o_byte_ready <= 1'b0;
              o_done       <= 1'b1;
              o_core_rst   <= 1'b0;
`endif
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (word_end) begin
            // Once the top address is written, later words
            // are consumed but dropped; addr stays at the top.
            if (!full) begin
              o_imem_we    <= 1'b1;
              o_imem_waddr <= addr;
              o_imem_wdata <= word[P_XLEN-1:0];
              if (addr == LAST_ADDR) begin
                full <= 1'b1;
              end else begin
                addr <= addr + 1'b1;
              end
            end else begin
              o_err <= 1'b1;
            end
`ifdef RISCV_IMEM_LOADER_CKSUM_EN
            sum <= sum + word;
`endif
            remain <= remain - 1'b1;
            if (remain == 32'd1) begin
`ifdef RISCV_IMEM_LOADER_CKSUM_EN
              state        <= S_CKSUM;
`else
              state        <= S_DONE;
              o_byte_ready <= 1'b0;
              o_done       <= 1'b1;
              o_core_rst   <= 1'b0;
`endif
            end
          end
        end
`ifdef RISCV_IMEM_LOADER_CKSUM_EN
        S_CKSUM: begin
          if (word_end) begin
            if (word != sum) begin
              o_err <= 1'b1;
            end
            state        <= S_DONE;
            o_byte_ready <= 1'b0;
            o_done       <= 1'b1;
            o_core_rst   <= 1'b0;
          end
        end
`endif
        default: begin
          state        <= S_IDLE;
          o_byte_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/riscv_imem_loader.md
# riscv_imem_loader

Byte-stream boot loader that fills the RV32I instruction memory before the core runs. It accepts a little-endian byte stream over a valid/ready handshake and packs every 4 bytes into one `XLEN` word. Each word is written to the instruction memory write port at consecutive word addresses. The core is held in reset until the image is complete. It sits between the host link (UART/JTAG byte source) and the instruction memory array, on the write side opposite the core's fetch read port.

## Interface
Parameters:
- `P_XLEN`, default `` `XLEN `` (32): instruction word width.
- `P_AW`, default `` `IMEM_ADDR_BIT-2 ``: word-address width; depth is `2**P_AW` words.

Ports:
- `i_clk`, in, 1: clock.
- `i_rst`, in, 1: asynchronous, active-high reset.
- `i_start`, in, 1: begin a load. Sampled only in IDLE or DONE.
- `i_byte`, in, 8: stream byte.
- `i_byte_valid`, in, 1: `i_byte` is valid.
- `o_byte_ready`, out, 1: loader accepts a byte this cycle.
- `o_imem_we`, out, 1: one-cycle write strobe.
- `o_imem_waddr`, out, `P_AW`: word write address.
- `o_imem_wdata`, out, `P_XLEN`: write data.
- `o_core_rst`, out, 1: hold the core in reset.
- `o_done`, out, 1: load finished.
- `o_err`, out, 1: load error, sticky until the next `i_start`.

## Operation
- Image format: a 4-byte length word N (count of instruction words, little-endian), then N words with each word's LSB first.
- Byte transfer happens on any cycle with `i_byte_valid & o_byte_ready`.
- State machine states: IDLE, LEN, DATA, CKSUM (present only with the macro), DONE.
- IDLE/DONE to LEN: on `i_start`. Clears the byte counter, word address, `o_err` and `o_done`, and asserts `o_core_rst`.
- LEN to DATA: after 4 bytes. If N == 0, go directly to CKSUM/DONE.
- DATA: a 2-bit byte index shifts bytes into a 32-bit assembler, byte k going to bits [8k+7:8k].
  - On the 4th byte, register the write.
  - Increment the word address.
  - Decrement the remaining count.
- DATA to CKSUM/DONE: after word N is accepted.
- Overflow: if N > `2**P_AW`, words past the last address are consumed but not written (`o_imem_we` stays 0), and `o_err` is set. The address never wraps.
- DONE: `o_done`=1, `o_core_rst`=0, `o_byte_ready`=0. Stays in DONE until `i_start`.
- `i_start` in LEN/DATA/CKSUM is ignored.
- `o_byte_ready` = 1 in LEN/DATA/CKSUM, 0 in IDLE/DONE. It has no combinational dependence on `i_byte_valid`.
- Asynchronous reset at any point, including mid-load:
  - State returns to IDLE.
  - Counters cleared.
  - Memory contents not touched.
  - The core stays in reset until a new complete load.

## Timing
- Reset values:
  - `o_byte_ready`=0, `o_imem_we`=0, `o_imem_waddr`=0, `o_imem_wdata`=0.
  - `o_core_rst`=1, `o_done`=0, `o_err`=0.
- Start: `i_start` at cycle t gives state LEN and `o_byte_ready`=1 at t+1.
- Write latency: 4th byte of a word accepted at cycle t gives `o_imem_we`=1 for exactly cycle t+1, with `waddr`/`wdata` valid in that same cycle.
- Throughput: one byte per cycle; back-to-back words produce a write every 4 cycles.
- Completion: the last byte accepted at t gives `o_done`=1 and `o_core_rst`=0 at t+1. The final write (if any) also occurs at t+1.
- Valid deasserted mid-word: the assembler holds and no partial write is issued.

## Configuration
- `RISCV_IMEM_LOADER_CKSUM_EN` defined:
  - CKSUM state is compiled in.
  - After the data, a 4-byte trailer is expected: the sum of all N data words mod 2^32, including dropped overflow words.
  - A mismatch sets `o_err`. DONE is still entered and `o_core_rst` is still released; system policy decides on `o_err`.
- Undefined: no trailer and no adder; `o_err` reports overflow only.

## Structure
- State encodings and the 2-bit byte-index width go in the shared `riscv_configs` header alongside `XLEN`/`IMEM_ADDR_BIT`.
- No sub-module required. The byte-to-word assembler (shift register plus index) may be split out as `riscv_byte_packer` if reused by a data-memory loader.

## Test plan
- Nominal load: N=2, words 0x00000013 and 0xDEADBEEF.
  - Two writes: addr 0 data 0x00000013, then addr 1 data 0xDEADBEEF.
  - `o_done`=1 one cycle after the last byte.
- Valid gaps: insert 3-cycle valid gaps inside each word. Writes are identical to the nominal load; no extra or partial `o_imem_we` pulses.
- Zero length: N=0. No writes; `o_done`=1 the cycle after the 4th length byte; `o_err`=0.
- Overflow: N = `2**P_AW`+1.
  - Writes at addresses 0..`2**P_AW`-1 only.
  - Last word dropped; `o_err`=1; address never returns to 0.
- Reset mid-DATA: assert `i_rst` after 6 bytes.
  - All outputs take reset values and `o_core_rst`=1.
  - A following full load of N=1 (0x12345678) writes addr 0 correctly.
- With `RISCV_IMEM_LOADER_CKSUM_EN`: N=2 words 1 and 2.
  - Trailer 3 gives `o_err`=0.
  - Trailer 4 gives `o_err`=1.
  - Both cases reach DONE.
